seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 28 ++
 rtl/seq_alu_iter.sv | 62 ++++++
 rtl/seq_alu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes, FSM state type and default width for seq_alu
// Optional feature macro: SEQ_ALU_DIV_EN adds the DIV state.
package seq_alu_pkg;
   localparam int WIDTH_DEF = 32;
   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_AND    = 5'b00010;
   localparam logic [4:0] OP_OR     = 5'b00011;
   localparam logic [4:0] OP_SLL    = 5'b00100;
   localparam logic [4:0] OP_SLT    = 5'b00101;
   localparam logic [4:0] OP_XOR    = 5'b00110;
   localparam logic [4:0] OP_SRL    = 5'b00111;
   localparam logic [4:0] OP_SLTU   = 5'b01101;
   localparam logic [4:0] OP_SRA    = 5'b01111;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b10011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;
   localparam logic [4:0] OP_REMU   = 5'b10111;
`ifdef SEQ_ALU_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shared shift-add multiply / restoring divide datapath and iteration counter
// Ports: clk, reset_n (async, active-low); load starts an operation with
// unsigned magnitudes opa (multiplier/dividend) and opb (multiplicand/divisor);
// run advances one iteration; div_mode (present only with SEQ_ALU_DIV_EN)
// selects divide steps; hi_nx/lo_nx are the values after the current
// iteration (product hi/lo, or remainder/quotient); last marks the final one.
module seq_alu_iter import seq_alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             run,
`ifdef SEQ_ALU_DIV_EN
   input  logic             div_mode,
`endif
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] hi_nx,
   output logic [WIDTH-1:0] lo_nx,
   output logic             last
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] hi, lo, opd;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum;
   // Multiply: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole product right one place.
   assign sum  = {1'b0, hi} + {1'b0, lo[0] ? opd : '0};
   assign last = cnt == CW'(WIDTH - 1);
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0] sh;
   logic           ge;
   // Divide: shift the next dividend bit into the partial remainder and
   // keep the subtraction only when it does not go negative.
   assign sh = {hi, lo[WIDTH-1]};
   assign ge = sh >= {1'b0, opd};
   always_comb begin
      hi_nx = div_mode ? (ge ? WIDTH'(sh - {1'b0, opd}) : sh[WIDTH-1:0]) : sum[WIDTH:1];
      lo_nx = div_mode ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
   end
`else
   assign hi_nx = sum[WIDTH:1];
   assign lo_nx = {sum[0], lo[WIDTH-1:1]};
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         hi  <= '0;
         lo  <= '0;
         opd <= '0;
         cnt <= '0;
      end else if (load) begin
         hi  <= '0;
         lo  <= opa;
         opd <= opb;
         cnt <= '0;
      end else if (run) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
         cnt <= last ? '0 : cnt + CW'(1);
      end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle base ops and iterative multiply/divide
// Ports: clk, reset_n (async, active-low); in_valid/in_ready accept op, a, b;
// out_valid/out_ready hand over result and zero; busy while iterating.
// Macro SEQ_ALU_DIV_EN enables DIV/DIVU/REM/REMU; without it they return 0.
module seq_alu import seq_alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);
   state_t             state, state_nx;
   logic [WIDTH-1:0]   result_nx, base_res, mag_a, mag_b, hi_nx, lo_nx, mul_res;
   logic [2*WIDTH-1:0] prod;
   logic [SHW-1:0]     shamt;
   logic [1:0]         op_q;
   logic               sa, sb, neg, neg_q, load, last, accept;
   assign shamt     = b[SHW-1:0];
   assign accept    = in_valid && in_ready;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign zero      = result == '0;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   logic [WIDTH-1:0] div_val, div_res;
   assign busy    = state == MUL || state == DIV;
   assign div_val = op_q[1] ? hi_nx : lo_nx;
   assign div_res = neg_q ? -div_val : div_val;
`else
   assign busy = state == MUL;
`endif
   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_AND:  base_res = a & b;
         OP_OR:   base_res = a | b;
         OP_XOR:  base_res = a ^ b;
         OP_SLL:  base_res = a << shamt;
         OP_SRL:  base_res = a >> shamt;
         OP_SRA:  base_res = $signed(a) >>> shamt;
         OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
         default: base_res = '0;
      endcase
   end
   // The iterative core works on magnitudes; the sign is reapplied at the end.
   // Quotient/product sign is sa^sb, remainder follows the dividend.
   assign sa    = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
   assign sb    = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;
   assign neg   = (op == OP_REM || op == OP_REMU) ? sa : sa ^ sb;
   assign prod  = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
   assign mul_res = op_q == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   always_comb begin
      state_nx  = state;
      result_nx = result;
      load      = 1'b0;
      unique case (state)
         IDLE: if (in_valid) begin
            if (!op[4]) begin
               state_nx  = DONE;
               result_nx = base_res;
            end else if (op[3:2] == 2'b00) begin
               state_nx = MUL;
               load     = 1'b1;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (op[3:2] == 2'b01 && b == '0) begin
               state_nx  = DONE;
               result_nx = op[1] ? a : '1;
            end else if (op[3:2] == 2'b01 && !op[0] && a == MIN && b == '1) begin
               state_nx  = DONE;
               result_nx = op[1] ? '0 : a;
            end else if (op[3:2] == 2'b01) begin
               state_nx = DIV;
               load     = 1'b1;
            end
`endif
            else begin
               state_nx  = DONE;
               result_nx = '0;
            end
         end
         MUL: if (last) begin
            state_nx  = DONE;
            result_nx = mul_res;
         end
`ifdef SEQ_ALU_DIV_EN
         DIV: if (last) begin
            state_nx  = DONE;
            result_nx = div_res;
         end
`endif
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         result <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
      end else begin
         result <= result_nx;
         if (accept) begin
            op_q  <= op[1:0];
            neg_q <= neg;
         end
      end
   seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk,
      .reset_n,
      .load,
      .run(busy),
`ifdef SEQ_ALU_DIV_EN
      .div_mode(state == DIV),
`endif
      .opa(mag_a),
      .opb(mag_b),
      .hi_nx,
      .lo_nx,
      .last
   );
endmodule
